// File: rtl/dtc_pkg.sv
// Shared types and constants for the decision-tree class vote accumulator.
package dtc_pkg;

  localparam int NUM_CLASSES = 8;
  localparam int CLS_W       = 3;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic logic is_last_class(input logic [CLS_W-1:0] idx);
    return idx == CLS_W'(NUM_CLASSES - 1);
  endfunction

endpackage

// File: rtl/dtc_vote_counter.sv
// One vote counter: synchronous clear wins over increment; never wraps because
// the owner stops accepting samples at the window size.
module dtc_vote_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_r + CNT_W'(1'b1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/dtc_vote_acc.sv
// Majority vote over a window of classifier decisions: accumulate, scan the
// eight vote counters for the argmax, then hold the result until taken.
module dtc_vote_acc
  import dtc_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_class,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_class,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_total
);

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] vote_s [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] inc_s;
  logic [CNT_W-1:0] sample_cnt_r, cnt_nxt_s;
  logic [2:0]       scan_idx_r, best_cls_r, sel_cls_s;
  logic [CNT_W-1:0] best_cnt_r, cand_cnt_s, sel_cnt_s;
  logic             accept_s, close_s, take_s, better_s, scan_last_s;
  logic             in_ready_r, out_valid_r;
  logic [2:0]       out_class_r;
  logic [CNT_W-1:0] out_count_r, out_total_r;

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_vote
    dtc_vote_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (take_s),
      .inc   (inc_s[i]),
      .count (vote_s[i])
    );
  end

  // acceptance, window close and argmax compare
  always_comb begin
    accept_s    = in_valid && in_ready_r && (state_r == ACC);
    cnt_nxt_s   = sample_cnt_r + CNT_W'(accept_s);
    // a flush counts the sample accepted in the same cycle
    close_s     = (accept_s && (cnt_nxt_s == CNT_W'(WINDOW))) ||
                  (flush && (cnt_nxt_s != '0));
    take_s      = out_valid_r && out_ready;
    cand_cnt_s  = vote_s[scan_idx_r];
    // strict compare keeps the lowest class code on a tie
    better_s    = cand_cnt_s > best_cnt_r;
    sel_cnt_s   = better_s ? cand_cnt_s : best_cnt_r;
    sel_cls_s   = better_s ? scan_idx_r : best_cls_r;
    scan_last_s = is_last_class(scan_idx_r);
    inc_s       = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      inc_s[i] = accept_s && (in_class == 3'(i));
    end
  end

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACC: begin
        if (close_s) state_nxt_s = SCAN;
        else         state_nxt_s = ACC;
      end
      SCAN: begin
        if (scan_last_s) state_nxt_s = OUT;
        else             state_nxt_s = SCAN;
      end
      OUT: begin
        if (take_s) state_nxt_s = ACC;
        else        state_nxt_s = OUT;
      end
      default: state_nxt_s = ACC;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ACC;
    else     state_r <= state_nxt_s;
  end

  // sample counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_r <= '0;
    end else if (take_s) begin
      sample_cnt_r <= '0;
    end else if (accept_s) begin
      sample_cnt_r <= cnt_nxt_s;
    end
  end

  // scan index and running best
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx_r <= 3'd0;
      best_cnt_r <= '0;
      best_cls_r <= 3'd0;
    end else if ((state_r == ACC) && close_s) begin
      scan_idx_r <= 3'd0;
      best_cnt_r <= '0;
      best_cls_r <= 3'd0;
    end else if (state_r == SCAN) begin
      scan_idx_r <= scan_idx_r + 3'd1;
      best_cnt_r <= sel_cnt_s;
      best_cls_r <= sel_cls_s;
    end
  end

  // registered handshake flags; out_valid trails entry to OUT by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == ACC);
      out_valid_r <= (state_r == OUT) && (state_nxt_s == OUT);
    end
  end

  // result registers, loaded as the last class is examined
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_class_r <= 3'd0;
      out_count_r <= '0;
      out_total_r <= '0;
    end else if ((state_r == SCAN) && scan_last_s) begin
      out_class_r <= sel_cls_s;
      out_count_r <= sel_cnt_s;
      out_total_r <= sample_cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_class = out_class_r;
  assign out_count = out_count_r;
  assign out_total = out_total_r;

endmodule
